mtx_hop_sched: RTL and testbench

- Frequency-hop scheduler that sequences the multi-tone transmit signal generator.
- Holds a small table of phase increments, one per tone.
- Streams the active increment to the generator's phase input over AXI-Stream: one beat per output sample, with TLAST at each symbol boundary.
- Counts symbols per frame and supports start, graceful stop and continuous mode.

---
 rtl/mtx_hop_sched.sv | 173 +++++++++++++++++
 tb/tb_mtx_hop_sched.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtx_hop_sched.sv
// Frequency-hop scheduler: streams one phase increment per output sample from a small
// tone table, hops to the next tone at every symbol boundary and counts symbols per frame.
module mtx_hop_sched #(
  parameter int unsigned PHASE_WIDTH = 24,
  parameter int unsigned NSYMB_WIDTH = 16,
  parameter int unsigned DWELL_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_wr_en,
  input  logic [ADDR_WIDTH-1:0]  cfg_addr,
  input  logic [PHASE_WIDTH-1:0] cfg_inc,
  input  logic [ADDR_WIDTH:0]    cfg_ntones,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic [NSYMB_WIDTH-1:0] cfg_nsymb,
  input  logic                   start,
  input  logic                   stop,
  output logic [PHASE_WIDTH-1:0] m_tdata,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic                   busy,
  output logic [ADDR_WIDTH-1:0]  tone_idx,
  output logic [NSYMB_WIDTH-1:0] symbN,
  output logic                   done,
  output logic                   cfg_err
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]    NtMax   = (ADDR_WIDTH + 1)'(Depth);
  localparam logic [ADDR_WIDTH:0]    NtOne   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0]  ToneOne = ADDR_WIDTH'(1);
  localparam logic [DWELL_WIDTH-1:0] DwOne   = DWELL_WIDTH'(1);
  localparam logic [NSYMB_WIDTH-1:0] SymOne  = NSYMB_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRun, StStopping} state_e;

  state_e                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] table_q [Depth];
  logic [PHASE_WIDTH-1:0] table_d [Depth];
  logic [ADDR_WIDTH:0]    ntones_q, ntones_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [NSYMB_WIDTH-1:0] nsymb_q, nsymb_d;
  logic [DWELL_WIDTH-1:0] sample_cnt_q, sample_cnt_d;
  logic [ADDR_WIDTH-1:0]  tone_idx_q, tone_idx_d;
  logic [NSYMB_WIDTH-1:0] symbn_q, symbn_d;
  logic [PHASE_WIDTH-1:0] tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   done_q, done_d;
  logic                   cfg_err_q, cfg_err_d;

  logic                  cfg_ok;
  logic                  beat;
  logic                  last;
  logic                  frame_end;
  logic [ADDR_WIDTH-1:0] tone_next;

  assign cfg_ok    = (cfg_ntones != '0) && (cfg_ntones <= NtMax) && (cfg_dwell != '0);
  assign beat      = tvalid_q & m_tready;
  // Gated by valid so an idle block with a stale dwell of 1 never shows TLAST.
  assign last      = tvalid_q && (sample_cnt_q == dwell_q - DwOne);
  // stop only matters in RUN; in STOPPING the boundary ends the frame regardless.
  assign frame_end = beat && last &&
                     ((state_q == StStopping) || stop ||
                      ((nsymb_q != '0) && (symbn_q == nsymb_q - SymOne)));
  assign tone_next = ({1'b0, tone_idx_q} == ntones_q - NtOne) ? '0 : tone_idx_q + ToneOne;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      table_q      <= '{default: '0};
      ntones_q     <= '0;
      dwell_q      <= '0;
      nsymb_q      <= '0;
      sample_cnt_q <= '0;
      tone_idx_q   <= '0;
      symbn_q      <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      table_q      <= table_d;
      ntones_q     <= ntones_d;
      dwell_q      <= dwell_d;
      nsymb_q      <= nsymb_d;
      sample_cnt_q <= sample_cnt_d;
      tone_idx_q   <= tone_idx_d;
      symbn_q      <= symbn_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (start && cfg_ok) state_d = StRun;
      StRun:      if (frame_end) state_d = StIdle;
                  else if (stop) state_d = StStopping;
      StStopping: if (frame_end) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Table writes, config latching and the per-beat / per-symbol datapath.
  always_comb begin
    table_d      = table_q;
    ntones_d     = ntones_q;
    dwell_d      = dwell_q;
    nsymb_d      = nsymb_q;
    sample_cnt_d = sample_cnt_q;
    tone_idx_d   = tone_idx_q;
    symbn_d      = symbn_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    done_d       = 1'b0;
    cfg_err_d    = 1'b0;

    if (cfg_wr_en) table_d[cfg_addr] = cfg_inc;

    if (state_q == StIdle) begin
      if (start) begin
        if (cfg_ok) begin
          ntones_d     = cfg_ntones;
          dwell_d      = cfg_dwell;
          nsymb_d      = cfg_nsymb;
          sample_cnt_d = '0;
          tone_idx_d   = '0;
          symbn_d      = '0;
          tdata_d      = table_q[0];
          tvalid_d     = 1'b1;
        end else begin
          cfg_err_d = 1'b1;
        end
      end
    end else if (beat) begin
      if (last) begin
        sample_cnt_d = '0;
        if (frame_end) begin
          // Final tone and symbol number stay visible until the next start.
          tvalid_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          tone_idx_d = tone_next;
          symbn_d    = symbn_q + SymOne;
          tdata_d    = table_q[tone_next];
        end
      end else begin
        sample_cnt_d = sample_cnt_q + DwOne;
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    m_tdata  = tdata_q;
    m_tvalid = tvalid_q;
    m_tlast  = last;
    busy     = (state_q != StIdle);
    tone_idx = tone_idx_q;
    symbN    = symbn_q;
    done     = done_q;
    cfg_err  = cfg_err_q;
  end

endmodule

// File: tb/tb_mtx_hop_sched.sv
// Self-checking bench for mtx_hop_sched: a per-cycle reference model of the hop schedule
// plus directed scenarios and randomized frames.
module tb_mtx_hop_sched;

  localparam int PW = 24;
  localparam int NW = 16;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_wr_en = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [PW-1:0] cfg_inc = '0;
  logic [AW:0]   cfg_ntones = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic [NW-1:0] cfg_nsymb = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [PW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b1;
  logic          busy;
  logic [AW-1:0] tone_idx;
  logic [NW-1:0] symbN;
  logic          done;
  logic          cfg_err;

  mtx_hop_sched #(
    .PHASE_WIDTH(PW),
    .NSYMB_WIDTH(NW),
    .DWELL_WIDTH(DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_wr_en (cfg_wr_en),
    .cfg_addr  (cfg_addr),
    .cfg_inc   (cfg_inc),
    .cfg_ntones(cfg_ntones),
    .cfg_dwell (cfg_dwell),
    .cfg_nsymb (cfg_nsymb),
    .start     (start),
    .stop      (stop),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready),
    .busy      (busy),
    .tone_idx  (tone_idx),
    .symbN     (symbN),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: frame described as symbol number, sample-in-symbol and tone.
  bit            m_run = 0;
  bit            m_stopping = 0;
  bit            m_done = 0;
  bit            m_err = 0;
  int            m_ntones = 1;
  int            m_dwell = 1;
  int            m_nsymb = 0;
  int            m_cnt = 0;
  int            m_sym = 0;
  int            m_tone = 0;
  logic [PW-1:0] m_data = '0;
  logic [PW-1:0] m_tbl [DEPTH];

  int            beat_cnt = 0;
  int            done_cnt = 0;
  int            err_cnt = 0;
  bit            sym4_seen = 0;
  logic [PW-1:0] sym4_first = '0;
  int            rdy_mode = 0;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_run = 0; m_stopping = 0; m_done = 0; m_err = 0;
        m_cnt = 0; m_sym = 0; m_tone = 0;
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = '0;
      end else begin
        check_eq("busy", 32'(busy), 32'(m_run));
        check_eq("tvalid", 32'(m_tvalid), 32'(m_run));
        check_eq("done", 32'(done), 32'(m_done));
        check_eq("cfg_err", 32'(cfg_err), 32'(m_err));
        check_eq("symbN", 32'(symbN), 32'(m_sym));
        check_eq("tone_idx", 32'(tone_idx), 32'(m_tone));
        if (m_run) begin
          check_eq("tdata", 32'(m_tdata), 32'(m_data));
          check_eq("tlast", 32'(m_tlast), 32'(m_cnt == m_dwell - 1));
        end
        if (done) done_cnt++;
        if (cfg_err) err_cnt++;
        m_done = 0;
        m_err = 0;
        if (!m_run) begin
          if (start) begin
            if (cfg_ntones == 0 || cfg_ntones > DEPTH || cfg_dwell == 0) begin
              m_err = 1;
            end else begin
              m_run = 1; m_stopping = 0;
              m_ntones = int'(cfg_ntones); m_dwell = int'(cfg_dwell);
              m_nsymb = int'(cfg_nsymb);
              m_cnt = 0; m_sym = 0; m_tone = 0; m_data = m_tbl[0];
            end
          end
        end else begin
          if (stop) m_stopping = 1;
          if (m_tready) begin
            beat_cnt++;
            if (m_sym == 4 && m_cnt == 0 && !sym4_seen) begin
              sym4_seen = 1;
              sym4_first = m_tdata;
            end
            if (m_cnt == m_dwell - 1) begin
              if (m_stopping || (m_nsymb != 0 && m_sym == m_nsymb - 1)) begin
                m_run = 0;
                m_done = 1;
              end else begin
                m_cnt = 0;
                m_sym = (m_sym + 1) % 65536;
                m_tone = (m_tone + 1) % m_ntones;
                m_data = m_tbl[m_tone];
              end
            end else begin
              m_cnt++;
            end
          end
        end
        // A write commits on the same edge as any table read above, so it lands afterwards.
        if (cfg_wr_en) m_tbl[cfg_addr] = cfg_inc;
      end
    end
  end

  // Ready source: always high, or a fair coin per cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [PW-1:0] val);
    cfg_wr_en = 1'b1;
    cfg_addr = AW'(addr);
    cfg_inc = val;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic pulse_start(input int nt, input int dw, input int ns);
    cfg_ntones = (AW + 1)'(nt);
    cfg_dwell = DW'(dw);
    cfg_nsymb = NW'(ns);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (m_run && i < budget) begin
      tick();
      i++;
    end
    if (m_run) check_eq("timeout_idle", 32'd0, 32'd1);
    tick();
    tick();
  endtask

  task automatic wait_beats(input int n, input int budget);
    int i = 0;
    while (beat_cnt < n && i < budget) begin
      tick();
      i++;
    end
    if (beat_cnt < n) check_eq("timeout_beats", 32'(beat_cnt), 32'(n));
  endtask

  task automatic load_basic();
    wr(0, 24'h000100);
    wr(1, 24'h000200);
    wr(2, 24'h000300);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_tdata"}, 32'(m_tdata), 32'd0);
    check_eq({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
    check_eq({tag, "_tlast"}, 32'(m_tlast), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_tone"}, 32'(tone_idx), 32'd0);
    check_eq({tag, "_symbN"}, 32'(symbN), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
  endtask

  initial begin
    int nt, dw, ns;
    repeat (3) tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    reset = 1'b0;
    tick();

    // Basic frame, ready held high.
    load_basic();
    beat_cnt = 0; done_cnt = 0;
    pulse_start(3, 4, 6);
    wait_idle(200);
    check_eq("basic_beats", 32'(beat_cnt), 32'd24);
    check_eq("basic_dones", 32'(done_cnt), 32'd1);
    check_eq("basic_symbN_end", 32'(symbN), 32'd5);
    check_eq("basic_tone_end", 32'(tone_idx), 32'd2);

    // Same frame under random backpressure.
    rdy_mode = 1;
    beat_cnt = 0; done_cnt = 0;
    pulse_start(3, 4, 6);
    wait_idle(2000);
    check_eq("bp_beats", 32'(beat_cnt), 32'd24);
    check_eq("bp_dones", 32'(done_cnt), 32'd1);
    rdy_mode = 0;
    tick();

    // Continuous mode, graceful stop after beat 6.
    beat_cnt = 0; done_cnt = 0;
    pulse_start(3, 4, 0);
    wait_beats(6, 100);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle(100);
    check_eq("stop_beats", 32'(beat_cnt), 32'd8);
    check_eq("stop_dones", 32'(done_cnt), 32'd1);
    check_eq("stop_symbN", 32'(symbN), 32'd1);
    check_eq("stop_busy", 32'(busy), 32'd0);

    // Rejected starts.
    err_cnt = 0; beat_cnt = 0;
    pulse_start(0, 4, 6);
    tick();
    pulse_start(17, 4, 6);
    tick();
    pulse_start(3, 0, 6);
    tick();
    tick();
    check_eq("cfg_err_count", 32'(err_cnt), 32'd3);
    check_eq("cfg_err_beats", 32'(beat_cnt), 32'd0);

    // Live write to tone 1 while it is streaming.
    beat_cnt = 0; done_cnt = 0; sym4_seen = 0;
    pulse_start(3, 4, 6);
    wait_beats(5, 100);
    wr(1, 24'h000ABC);
    wait_idle(200);
    check_eq("live_sym4_data", 32'(sym4_first), 32'h000ABC);
    check_eq("live_beats", 32'(beat_cnt), 32'd24);

    // Reset in the middle of a frame.
    wr(1, 24'h000200);
    beat_cnt = 0; done_cnt = 0;
    pulse_start(3, 4, 6);
    wait_beats(9, 100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    check_eq("midreset_dones", 32'(done_cnt), 32'd0);
    tick();
    load_basic();
    beat_cnt = 0; done_cnt = 0;
    pulse_start(3, 4, 6);
    wait_idle(200);
    check_eq("restart_beats", 32'(beat_cnt), 32'd24);
    check_eq("restart_dones", 32'(done_cnt), 32'd1);

    // Randomized frames, including dwell of 1 and full-depth tables.
    rdy_mode = 1;
    for (int f = 0; f < 6; f++) begin
      for (int a = 0; a < DEPTH; a++) wr(a, PW'($urandom));
      nt = int'($urandom_range(1, DEPTH));
      dw = int'($urandom_range(1, 4));
      ns = int'($urandom_range(1, 6));
      beat_cnt = 0; done_cnt = 0;
      pulse_start(nt, dw, ns);
      wait_idle(3000);
      check_eq("rand_beats", 32'(beat_cnt), 32'(dw * ns));
      check_eq("rand_dones", 32'(done_cnt), 32'd1);
    end
    rdy_mode = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
